// File: rtl/dmem_uart_tx.sv
// dmem_uart_tx: reads a MSG_LEN-byte message from d_memory and sends it as 8N1 UART frames.
// Each byte costs three read cycles, a ten-bit frame and one NEXT cycle.
// Optional feature: define DMEM_UART_CRLF_EN to append 0x0D, 0x0A frames after the message.
module dmem_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned MSG_LEN      = 32
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  output logic [4:0] d_address,
  input  logic [7:0] d_q,
  output logic       txd,
  output logic       busy,
  output logic       done
);

  localparam int unsigned     CntW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [4:0]      LastIdx = 5'(MSG_LEN - 1);

  typedef enum logic [3:0] {
    StIdle,
    StRdAddr,
    StRdWait,
    StRdLatch,
    StTxStart,
    StTxData,
    StTxStop,
    StNext,
    StDone
  } state_e;

  state_e          state_q;
  logic [4:0]      idx_q;
  logic [7:0]      sh_q;
  logic [2:0]      bc_q;
  logic [CntW-1:0] cnt_q;
  logic [4:0]      d_address_q;
  logic            txd_q;
  logic            busy_q;
  logic            done_q;
`ifdef DMEM_UART_CRLF_EN
  // Number of line-terminator frames already started after the last message byte.
  logic [1:0]      crlf_q;
`endif

  assign d_address = d_address_q;
  assign txd       = txd_q;
  assign busy      = busy_q;
  assign done      = done_q;

  // Readout/transmit FSM; every output is a register so txd never glitches.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      sh_q        <= '0;
      bc_q        <= '0;
      cnt_q       <= '0;
      d_address_q <= '0;
      txd_q       <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef DMEM_UART_CRLF_EN
      crlf_q      <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            idx_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            state_q <= StRdAddr;
`ifdef DMEM_UART_CRLF_EN
            crlf_q  <= '0;
`endif
          end
        end
        StRdAddr: begin
          d_address_q <= idx_q;
          state_q     <= StRdWait;
        end
        StRdWait: begin
          state_q <= StRdLatch;
        end
        StRdLatch: begin
          // d_q now reflects the address driven two edges ago.
          sh_q    <= d_q;
          bc_q    <= '0;
          cnt_q   <= '0;
          txd_q   <= 1'b0;
          state_q <= StTxStart;
        end
        StTxStart: begin
          if (cnt_q == CntLast) begin
            cnt_q   <= '0;
            txd_q   <= sh_q[0];
            state_q <= StTxData;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StTxData: begin
          if (cnt_q == CntLast) begin
            cnt_q <= '0;
            sh_q  <= sh_q >> 1;
            bc_q  <= bc_q + 1'b1;
            if (bc_q == 3'd7) begin
              txd_q   <= 1'b1;
              state_q <= StTxStop;
            end else begin
              txd_q <= sh_q[1];
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StTxStop: begin
          if (cnt_q == CntLast) begin
            cnt_q   <= '0;
            state_q <= StNext;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StNext: begin
          if (idx_q != LastIdx) begin
            idx_q   <= idx_q + 5'd1;
            state_q <= StRdAddr;
`ifdef DMEM_UART_CRLF_EN
          end else if (crlf_q != 2'd2) begin
            // Terminator bytes bypass the memory read and go straight to the start bit.
            sh_q    <= (crlf_q == 2'd0) ? 8'h0D : 8'h0A;
            crlf_q  <= crlf_q + 2'd1;
            bc_q    <= '0;
            cnt_q   <= '0;
            txd_q   <= 1'b0;
            state_q <= StTxStart;
`endif
          end else begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_uart_tx.sv
// Bench for dmem_uart_tx: a frame-timing model predicts txd/busy/done/d_address every cycle,
// a UART receiver decodes the line, and directed runs pin the model with literal values.
module tb_dmem_uart_tx;

  localparam int C  = 4;
  localparam int L  = 32;
  localparam int P  = 10 * C + 4;
  localparam int FR = 10 * C;
`ifdef DMEM_UART_CRLF_EN
  localparam int NX      = 2;
  localparam int ExpRun  = 1490;
  localparam int ExpNum  = 34;
`else
  localparam int NX      = 0;
  localparam int ExpRun  = 1408;
  localparam int ExpNum  = 32;
`endif
  localparam int NF    = L + NX;
  localparam int TDone = 3 + (L - 1) * P + (NX + 1) * (FR + 1);

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [4:0] d_address;
  logic [7:0] d_q;
  logic       txd;
  logic       busy;
  logic       done;

  logic [7:0] mem [32];
  logic [7:0] q_r = 8'h00;
  logic [7:0] rxq [$];
  logic [7:0] rx_b;
  logic       rx_stop;

  int n_checks = 0;
  int n_fail   = 0;

  dmem_uart_tx #(
    .CLKS_PER_BIT(C),
    .MSG_LEN     (L)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .start    (start),
    .d_address(d_address),
    .d_q      (d_q),
    .txd      (txd),
    .busy     (busy),
    .done     (done)
  );

  initial forever #5 clk = ~clk;

  // d_memory: data for an address appears two edges after the address is driven.
  always @(posedge clk) q_r <= mem[d_address];
  assign d_q = q_r;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-timing model ----------------
  function automatic int frame_start(input int f);
    if (f < L) return 3 + f * P;
    return 3 + (L - 1) * P + (f - L + 1) * (FR + 1);
  endfunction

  function automatic logic [7:0] frame_byte(input int f);
    if (f < L) return mem[f];
    if (f == L) return 8'h0D;
    return 8'h0A;
  endfunction

  function automatic logic exp_txd(input int t);
    for (int f = 0; f < NF; f++) begin
      int s;
      s = frame_start(f);
      if (t >= s && t < s + FR) begin
        int b;
        logic [7:0] v;
        b = (t - s) / C;
        v = frame_byte(f);
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return v[b-1];
      end
    end
    return 1'b1;
  endfunction

  function automatic int exp_addr(input int t);
    int k;
    k = 0;
    for (int f = 0; f < L; f++) if (frame_start(f) - 2 <= t) k = f;
    return k;
  endfunction

  int cyc = 0;
  int acc = 0;
  bit active = 1'b0;

  // Track which edge accepted the latest start; only accepted in idle or done.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      active <= 1'b0;
      cyc    <= 0;
      acc    <= 0;
    end else begin
      if (start && (!active || (cyc - acc) >= TDone)) begin
        active <= 1'b1;
        acc    <= cyc + 1;
      end
      cyc <= cyc + 1;
    end
  end

  // Per-cycle comparison against the model, sampled away from the active edge.
  always @(negedge clk) begin
    int t;
    if (active) begin
      t = cyc - acc;
      chk("m_txd", int'(txd), int'(exp_txd(t)));
      chk("m_busy", int'(busy), (t < TDone) ? 1 : 0);
      chk("m_done", int'(done), (t >= TDone) ? 1 : 0);
      if (t >= 1) chk("m_addr", int'(d_address), exp_addr(t));
    end else begin
      chk("m_idle_txd", int'(txd), 1);
      chk("m_idle_busy", int'(busy), 0);
      chk("m_idle_done", int'(done), 0);
      chk("m_idle_addr", int'(d_address), 0);
    end
  end

  // UART receiver: mid-bit sampling, LSB first.
  initial begin
    forever begin
      @(negedge clk);
      if (reset && txd === 1'b0) begin
        repeat (C / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (C) @(negedge clk);
          rx_b[i] = txd;
        end
        repeat (C) @(negedge clk);
        rx_stop = txd;
        rxq.push_back(rx_b);
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for done; optionally pokes start during the run, which must be ignored.
  task automatic run_wait(input bit poke, output int n);
    n = 0;
    while (!done && n < 4000) begin
      @(negedge clk);
      n++;
      start = poke && (n % 97 == 20) && (n < 1300);
    end
    start = 1'b0;
  endtask

  int         n;
  logic [9:0] bits;
  logic [9:0] exp_bits;
  string      msg;

  initial begin
    msg = "the quick brown fox jumps over t";
    for (int i = 0; i < 32; i++) mem[i] = msg[i];

    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (100) @(negedge clk);
    chk("idle_txd", int'(txd), 1);
    chk("idle_busy", int'(busy), 0);
    chk("idle_done", int'(done), 0);
    chk("idle_addr", int'(d_address), 0);

    // Full message with stray starts during transmission.
    rxq.delete();
    pulse_start();
    chk("accept_busy", int'(busy), 1);
    run_wait(1'b1, n);
    chk("run1_cycles", n, ExpRun);
    chk("run1_done", int'(done), 1);
    chk("run1_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    chk("run1_nbytes", rxq.size(), ExpNum);
    if (rxq.size() == ExpNum) begin
      chk("run1_first", int'(rxq[0]), 8'h74);
      chk("run1_last_msg", int'(rxq[L-1]), 8'h74);
`ifdef DMEM_UART_CRLF_EN
      chk("run1_cr", int'(rxq[L]), 8'h0D);
      chk("run1_lf", int'(rxq[L+1]), 8'h0A);
`endif
    end

    // Restart from DONE.
    rxq.delete();
    pulse_start();
    chk("restart_done_drop", int'(done), 0);
    chk("restart_busy", int'(busy), 1);
    run_wait(1'b0, n);
    chk("run2_cycles", n, ExpRun);
    repeat (3) @(negedge clk);
    chk("run2_nbytes", rxq.size(), ExpNum);

    // 0x01 at address 0: bits after start must be 1 then seven 0s, then stop.
    mem[0] = 8'h01;
    pulse_start();
    repeat (5) @(negedge clk);
    bits[0] = txd;
    for (int b = 1; b < 10; b++) begin
      repeat (C) @(negedge clk);
      bits[b] = txd;
    end
    exp_bits = 10'b10_0000_0010;
    chk("byte01_frame", int'(bits), int'(exp_bits));

    // Asynchronous reset in the middle of byte 5's data bits (t=240).
    repeat (199) @(negedge clk);
    chk("pre_reset_busy", int'(busy), 1);
    #2 reset = 1'b0;
    #1;
    chk("async_txd", int'(txd), 1);
    chk("async_busy", int'(busy), 0);
    chk("async_done", int'(done), 0);
    chk("async_addr", int'(d_address), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (60) @(negedge clk);

    // Resend after reset starts again from address 0.
    mem[0] = 8'h74;
    rxq.delete();
    pulse_start();
    run_wait(1'b0, n);
    chk("run3_cycles", n, ExpRun);
    repeat (3) @(negedge clk);
    chk("run3_nbytes", rxq.size(), ExpNum);
    if (rxq.size() > 0) chk("run3_first", int'(rxq[0]), 8'h74);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
